// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encodings and a parameter-legality check.
// Used at elaboration only; no logic, no latency, no flow control.
package fifo_pkg;

    localparam int FIFO_RD_MODE_REG  = 0;
    localparam int FIFO_RD_MODE_FWFT = 1;

    function automatic logic fifo_params_ok(
        input int depth,
        input int rd_mode,
        input int afull_thres,
        input int aempty_thres
    );
        logic ok;
        ok = (depth >= 2) && ((depth & (depth - 1)) == 0);
        ok = ok && ((rd_mode == FIFO_RD_MODE_REG) || (rd_mode == FIFO_RD_MODE_FWFT));
        ok = ok && (afull_thres >= 1) && (afull_thres <= depth);
        ok = ok && (aempty_thres >= 0) && (aempty_thres <= depth - 1);
        return ok;
    endfunction

endpackage

// File: rtl/fifo_ctl_ptr.sv
// FIFO bookkeeping: pointers, occupancy and status flags; updates one edge after an accept.
// Caller qualifies accepts against full/empty; flush overrides both and zeroes all state.
module fifo_ctl_ptr #(
    parameter int  FIFO_DEPTH   = 16,
    parameter int  AFULL_THRES  = 12,
    parameter int  AEMPTY_THRES = 4,
    localparam int PTRS_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_acc,
    input  logic                  rd_acc,
    output logic [PTRS_WIDTH-1:0] wr_ptr,
    output logic [PTRS_WIDTH-1:0] rd_ptr,
    output logic [PTRS_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty
);

    localparam int LVL_W = PTRS_WIDTH + 1;
    localparam logic [PTRS_WIDTH:0] DEPTH_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [PTRS_WIDTH:0] AFULL_LVL  = LVL_W'(AFULL_THRES);
    localparam logic [PTRS_WIDTH:0] AEMPTY_LVL = LVL_W'(AEMPTY_THRES);

    // Depth is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)
                level <= level + 1'b1;
            else if (rd_acc && !wr_acc)
                level <= level - 1'b1;
        end
    end

    assign full   = (level == DEPTH_LVL);
    assign empty  = (level == '0);
    assign afull  = (level >= AFULL_LVL);
    assign aempty = (level <= AEMPTY_LVL);

endmodule

// File: rtl/fifo_mode_s_ctl.sv
// Single-clock FIFO with registered or first-word-fall-through read, thresholds, flush, sticky errors.
// Registered read data one edge after accept (FWFT: head visible after write edge); full/empty reject requests.
module fifo_mode_s_ctl
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  FIFO_DEPTH   = 16,
    parameter int  RD_MODE      = 0,
    parameter int  AFULL_THRES  = 12,
    parameter int  AEMPTY_THRES = 4,
    localparam int PTRS_WIDTH   = $clog2(FIFO_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_full,
    output logic                  o_wr_afull,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_rd_empty,
    output logic                  o_rd_aempty,
    output logic [PTRS_WIDTH:0]   o_level,
    output logic                  o_ovf,
    output logic                  o_udf
);

    if (!fifo_params_ok(FIFO_DEPTH, RD_MODE, AFULL_THRES, AEMPTY_THRES)) begin : g_param_err
        $error("fifo_mode_s_ctl: illegal DEPTH/RD_MODE/threshold parameters");
    end

    logic [PTRS_WIDTH-1:0] wr_ptr;
    logic [PTRS_WIDTH-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // Flush swallows any request issued in the same cycle.
    assign wr_acc = i_wr_en && !full  && !i_flush;
    assign rd_acc = i_rd_en && !empty && !i_flush;

    fifo_ctl_ptr #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .AFULL_THRES  (AFULL_THRES),
        .AEMPTY_THRES (AEMPTY_THRES)
    ) u_ctl (
        .clk    (i_clk),
        .rst    (i_rst),
        .flush  (i_flush),
        .wr_acc (wr_acc),
        .rd_acc (rd_acc),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .level  (o_level),
        .full   (full),
        .empty  (empty),
        .afull  (o_wr_afull),
        .aempty (o_rd_aempty)
    );

    assign o_wr_full  = full;
    assign o_rd_empty = empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else if (i_flush) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            if (i_wr_en && full)  o_ovf <= 1'b1;
            if (i_rd_en && empty) o_udf <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wr_ptr] <= i_wr_data;
    end

    if (RD_MODE == FIFO_RD_MODE_FWFT) begin : g_fwft
        // Zero while empty so the output is defined before anything is written.
        assign o_rd_data  = empty ? '0 : mem[rd_ptr];
        assign o_rd_valid = !empty;
    end else begin : g_reg
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                o_rd_data  <= '0;
                o_rd_valid <= 1'b0;
            end else if (i_flush) begin
                o_rd_valid <= 1'b0;
            end else if (rd_acc) begin
                o_rd_data  <= mem[rd_ptr];
                o_rd_valid <= 1'b1;
            end else begin
                o_rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_mode_s_ctl.sv
// Drives one registered-mode and one FWFT FIFO with identical stimulus, checked against a queue model.
module tb_fifo_mode_s_ctl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_flush;
    logic          i_wr_en;
    logic [DW-1:0] i_wr_data;
    logic          i_rd_en;

    logic          r_full, r_afull, r_valid, r_empty, r_aempty, r_ovf, r_udf;
    logic [DW-1:0] r_data;
    logic [4:0]    r_level;
    logic          f_full, f_afull, f_valid, f_empty, f_aempty, f_ovf, f_udf;
    logic [DW-1:0] f_data;
    logic [4:0]    f_level;

    always #5 i_clk = ~i_clk;

    fifo_mode_s_ctl #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RD_MODE(0),
        .AFULL_THRES(AF), .AEMPTY_THRES(AE)
    ) dut_reg (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
        .o_wr_full(r_full), .o_wr_afull(r_afull),
        .i_rd_en(i_rd_en), .o_rd_data(r_data), .o_rd_valid(r_valid),
        .o_rd_empty(r_empty), .o_rd_aempty(r_aempty), .o_level(r_level),
        .o_ovf(r_ovf), .o_udf(r_udf)
    );

    fifo_mode_s_ctl #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RD_MODE(1),
        .AFULL_THRES(AF), .AEMPTY_THRES(AE)
    ) dut_fwft (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
        .o_wr_full(f_full), .o_wr_afull(f_afull),
        .i_rd_en(i_rd_en), .o_rd_data(f_data), .o_rd_valid(f_valid),
        .o_rd_empty(f_empty), .o_rd_aempty(f_aempty), .o_level(f_level),
        .o_ovf(f_ovf), .o_udf(f_udf)
    );

    int          checks = 0;
    int          errors = 0;
    bit          running = 1'b0;
    logic [DW-1:0] fq[$];     // words held by the FIFO, head first
    logic [DW-1:0] exp_q[$];  // words due on the registered output
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        fq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Queue-level behaviour at one rising edge, using the inputs presented before it.
    task automatic model_step();
        int sz;
        sz = fq.size();
        if (i_rst) begin
            model_clear();
        end else if (i_flush) begin
            fq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (i_wr_en && sz == DEPTH) m_ovf = 1'b1;
            if (i_rd_en && sz == 0)     m_udf = 1'b1;
            if (i_rd_en && sz > 0)      exp_q.push_back(fq.pop_front());
            if (i_wr_en && sz < DEPTH)  fq.push_back(i_wr_data);
        end
    endtask

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        i_wr_en   = w;
        i_wr_data = d;
        i_rd_en   = r;
        i_flush   = f;
        @(posedge i_clk);
        model_step();
        #2;
    endtask

    task automatic check_reset_vals();
        chk("rst_level", 32'(r_level), 0);
        chk("rst_empty", 32'(r_empty), 1);
        chk("rst_aempty", 32'(r_aempty), 1);
        chk("rst_full", 32'(r_full), 0);
        chk("rst_afull", 32'(r_afull), 0);
        chk("rst_valid", 32'(r_valid), 0);
        chk("rst_data", r_data, 0);
        chk("rst_ovf", 32'(r_ovf), 0);
        chk("rst_udf", 32'(r_udf), 0);
        chk("rst_fwft_level", 32'(f_level), 0);
        chk("rst_fwft_valid", 32'(f_valid), 0);
        chk("rst_fwft_data", f_data, 0);
    endtask

    // Monitor: compares both DUTs against the model away from the active edge.
    always @(negedge i_clk) begin
        if (running) begin
            int sz;
            logic [DW-1:0] e;
            sz = fq.size();
            chk("level", 32'(r_level), 32'(sz));
            chk("full", 32'(r_full), 32'(sz == DEPTH));
            chk("empty", 32'(r_empty), 32'(sz == 0));
            chk("afull", 32'(r_afull), 32'(sz >= AF));
            chk("aempty", 32'(r_aempty), 32'(sz <= AE));
            chk("ovf", 32'(r_ovf), 32'(m_ovf));
            chk("udf", 32'(r_udf), 32'(m_udf));
            chk("fwft_level", 32'(f_level), 32'(sz));
            chk("fwft_full", 32'(f_full), 32'(sz == DEPTH));
            chk("fwft_afull", 32'(f_afull), 32'(sz >= AF));
            chk("fwft_aempty", 32'(f_aempty), 32'(sz <= AE));
            chk("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
            chk("fwft_udf", 32'(f_udf), 32'(m_udf));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("reg_valid", 32'(r_valid), 1);
                chk("reg_data", r_data, e);
            end else begin
                chk("reg_valid", 32'(r_valid), 0);
            end
            chk("fwft_valid", 32'(f_valid), 32'(sz > 0));
            chk("fwft_empty", 32'(f_empty), 32'(sz == 0));
            if (sz > 0) chk("fwft_data", f_data, fq[0]);
        end
    end

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_wr_data = '0;
        #1;
        check_reset_vals();
        running = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        i_rst = 1'b0;
        cyc(0, 0, 0, 0);

        // Fill to full, then drain in order.
        for (int i = 0; i < 16; i++) cyc(1, 32'(i), 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Thresholds: up to 12, down to 4.
        for (int i = 0; i < 12; i++) cyc(1, 32'h20 + 32'(i), 0, 0);
        for (int i = 0; i < 8; i++)  cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Full boundary: simultaneous write+read drops the write, sets ovf.
        for (int i = 0; i < 12; i++) cyc(1, 32'h40 + 32'(i), 0, 0);
        cyc(1, 32'hDEAD_BEEF, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 0);
        // Empty boundary: simultaneous write+read keeps the write, sets udf.
        cyc(1, 32'h5A, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);

        // Wrap: hold level at 3 while streaming.
        for (int i = 0; i < 3; i++)  cyc(1, 32'h100 + 32'(i), 0, 0);
        for (int i = 3; i < 43; i++) cyc(1, 32'h100 + 32'(i), 1, 0);
        for (int i = 0; i < 3; i++)  cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // FWFT visibility of a single word, then pop.
        cyc(1, 32'hA5, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Flush at level 9 with ovf set; the concurrent write must not land.
        for (int i = 0; i < 17; i++) cyc(1, 32'h200 + 32'(i), 0, 0);
        for (int i = 0; i < 7; i++)  cyc(0, 0, 1, 0);
        cyc(1, 32'hBAD, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 32'h77, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), $urandom(),
                1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 59) == 0));
        end

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 6; i++) cyc(1, 32'h300 + 32'(i), 0, 0);
        i_rst = 1'b1;
        #1;
        check_reset_vals();
        model_clear();
        cyc(1, 32'h3FF, 0, 0);
        i_rst = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(1, 32'h400, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
